br_sequencer: RTL and testbench
===============================

# br_sequencer

Control-side consumer of the branch-enable bit for the LC-3 datapath. On each decoded instruction it pulses `ld_ben` so the BEN register captures `(IR[11]&N)|(IR[10]&Z)|(IR[9]&P)`, then samples the registered `ben` one cycle later. For BR opcodes it drives the PC-load and address-mux controls for `PC <= PC + SEXT(IR[8:0])` when `ben` is set. It also keeps saturating taken/not-taken counts for debug.

## Interface
- `OPCODE_BR`, default `4'b0000`: opcode value in IR[15:12] treated as a branch.
- `CNT_W`, default `16`: width of each branch counter.

- `clk`  in  1  system clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high.
- `decode_start`  in  1  one-cycle pulse: `ir` holds a freshly fetched instruction.
- `ir`  in  16  instruction register contents, stable from `decode_start` until `done`.
- `ben`  in  1  registered branch-enable from the BEN register.
- `ld_ben`  out  1  load strobe to the BEN register.
- `ld_pc`  out  1  PC load strobe.
- `pcmux_sel`  out  2  `00` PC+1, `01` address adder, `10` bus.
- `addr1mux_sel`  out  1  `0` selects PC.
- `addr2mux_sel`  out  2  `10` selects SEXT(IR[8:0]).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `taken`  out  1  valid only with `done`: branch was taken.
- `taken_cnt`  out  CNT_W  saturating count of taken branches.
- `not_taken_cnt`  out  CNT_W  saturating count of BR instructions not taken.

## Operation
- FSM states: IDLE, DECODE, CHECK, TAKEN, DONE.
- IDLE:
  - All strobes are 0.
  - `decode_start=1` moves to DECODE.
- DECODE:
  - `ld_ben=1` for exactly one cycle, for every opcode.
  - If IR[15:12]==OPCODE_BR, go to CHECK. Otherwise go to DONE with the taken flag cleared.
- CHECK:
  - Samples `ben`, which the BEN register loaded at the DECODE/CHECK edge.
  - `ben=1` goes to TAKEN.
  - `ben=0` goes to DONE with taken cleared and increments `not_taken_cnt`.
- TAKEN:
  - Drives `ld_pc=1`, `pcmux_sel=01`, `addr1mux_sel=0`, `addr2mux_sel=10` for one cycle.
  - Sets the taken flag, increments `taken_cnt`, then goes to DONE.
- DONE:
  - `done=1` and `taken` equals the internal flag.
  - Returns to IDLE.
- Output defaults: in every state other than TAKEN, `pcmux_sel=00`, `addr1mux_sel=0`, `addr2mux_sel=00`, `ld_pc=0`.
- Counters:
  - Each counter increments by 1 and saturates at all-ones; it never wraps.
  - Only `reset` clears them.
- `decode_start` while `busy=1` is ignored. No queuing; the pulse is dropped.
- BR with IR[11:9]=000 is a normal BR. BEN evaluates to 0, so it counts as not taken.

## Timing
- Cycle 0 is the cycle in which `decode_start` is sampled high in IDLE.
- Cycle 1: DECODE, `ld_ben=1`.
- Cycle 2: CHECK for BR. For non-BR, DONE with `done=1`, `taken=0`.
- BR not taken: cycle 3 DONE (`done=1`, `taken=0`). `not_taken_cnt` updates visibly in cycle 3.
- BR taken: cycle 3 TAKEN (`ld_pc=1`), cycle 4 DONE (`done=1`, `taken=1`). `taken_cnt` updates visibly in cycle 4.
- `decode_start` may be accepted again in the cycle after DONE, when the FSM is back in IDLE.
- All outputs are registered-state decodes (Moore); no combinational path from `ben` or `ir` to any strobe.
- Reset values: state IDLE; all outputs 0, including both counters.
- Reset mid-operation:
  - Takes effect on the next edge and forces IDLE.
  - An in-flight TAKEN cycle aborts: `ld_pc` is 0 from the reset edge on.
  - No `done` pulse for the aborted instruction; counters clear to 0.

## Structure
- Shared package `lc3_ctrl_pkg` holds:
  - the `br_state_t` enum;
  - `OPCODE_BR`;
  - named constants for PCMUX, ADDR1MUX and ADDR2MUX select codes, shared with the main control FSM.
- One natural sub-module, `sat_counter` (parameter width; inputs `clk`, `reset`, `inc`; output `count`), instantiated twice.

## Test plan
- Taken branch:
  - Stimulus: reset, then `decode_start` with `ir=16'h0405` (BRz, offset 5); the BEN model is fed Z=1, N=P=0.
  - Required: `ld_ben` in cycle 1; `ld_pc=1`, `pcmux_sel=01`, `addr2mux_sel=10` in cycle 3; `done=1`, `taken=1` in cycle 4; `taken_cnt=1`.
- Not-taken branch:
  - Stimulus: `ir=16'h0405` with P=1, Z=0.
  - Required: no `ld_pc`; `done=1`, `taken=0` in cycle 3; `not_taken_cnt=1`.
- Non-branch opcode:
  - Stimulus: `ir=16'h1261` (ADD).
  - Required: `ld_ben` in cycle 1; `done` in cycle 2; counters unchanged; `ld_pc` never asserted.
- Busy and NOP branch:
  - Stimulus: `decode_start` pulsed again in cycles 1–3 of a taken branch; separately, `ir=16'h0000`.
  - Required: extra pulses are ignored, with exactly one `done`; `ir=16'h0000` reports not taken.
- Reset mid-operation:
  - Stimulus: `reset` asserted during cycle 3 (TAKEN) with prior counts 5/7.
  - Required: from the following edge, `ld_pc=0`, `busy=0`, counters 0, and no `done`.
- Saturation:
  - Stimulus: CNT_W=4; 17 taken branches.
  - Required: `taken_cnt` stays at 4'hF.

Source files
------------

// File: rtl/lc3_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | lc3_ctrl_pkg : LC-3 control-side shared types and mux select codes |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package lc3_ctrl_pkg;

    typedef enum logic [2:0] {
        BR_IDLE   = 3'd0,
        BR_DECODE = 3'd1,
        BR_CHECK  = 3'd2,
        BR_TAKEN  = 3'd3,
        BR_DONE   = 3'd4
    } br_state_t;

    localparam logic [3:0] OPCODE_BR = 4'b0000;

    // Select codes are shared with the main control FSM, so all legal values are listed.
    localparam logic [1:0] PCMUX_PC_INC = 2'b00;
    localparam logic [1:0] PCMUX_ADDER  = 2'b01;
    localparam logic [1:0] PCMUX_BUS    = 2'b10;

    localparam logic       ADDR1MUX_PC    = 1'b0;
    localparam logic       ADDR1MUX_BASER = 1'b1;

    localparam logic [1:0] ADDR2MUX_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2MUX_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2MUX_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2MUX_OFF11 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +--------------------------------------------------------------------+
// | sat_counter : increment-by-one counter that holds at all-ones      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/br_sequencer.sv
// +--------------------------------------------------------------------+
// | br_sequencer : BEN load / BR resolve sequencer with debug counters |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module br_sequencer #(
    parameter logic [3:0] OPCODE_BR = lc3_ctrl_pkg::OPCODE_BR,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             decode_start,
    input  logic [15:0]      ir,
    input  logic             ben,
    output logic             ld_ben,
    output logic             ld_pc,
    output logic [1:0]       pcmux_sel,
    output logic             addr1mux_sel,
    output logic [1:0]       addr2mux_sel,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt
);

    import lc3_ctrl_pkg::*;

    br_state_t state;
    br_state_t state_next;
    logic      taken_flag;
    logic      taken_flag_next;
    logic      inc_taken;
    logic      inc_not_taken;
    logic      is_br;

    // Only the opcode field matters here; the NZP/offset bits feed the datapath.
    logic      unused_ir;
    assign unused_ir = ^ir[11:0];

    assign is_br = (ir[15:12] == OPCODE_BR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BR_IDLE;
            taken_flag <= 1'b0;
        end else begin
            state      <= state_next;
            taken_flag <= taken_flag_next;
        end
    end

    always_comb begin
        state_next      = state;
        taken_flag_next = taken_flag;
        inc_taken       = 1'b0;
        inc_not_taken   = 1'b0;
        unique case (state)
            BR_IDLE: begin
                if (decode_start) state_next = BR_DECODE;
            end
            BR_DECODE: begin
                taken_flag_next = 1'b0;
                state_next      = is_br ? BR_CHECK : BR_DONE;
            end
            BR_CHECK: begin
                // ben here reflects the BEN register loaded at the DECODE/CHECK edge.
                if (ben) begin
                    state_next = BR_TAKEN;
                end else begin
                    inc_not_taken = 1'b1;
                    state_next    = BR_DONE;
                end
            end
            BR_TAKEN: begin
                taken_flag_next = 1'b1;
                inc_taken       = 1'b1;
                state_next      = BR_DONE;
            end
            BR_DONE: begin
                state_next = BR_IDLE;
            end
            default: begin
                state_next = BR_IDLE;
            end
        endcase
    end

    always_comb begin
        ld_ben       = (state == BR_DECODE);
        ld_pc        = 1'b0;
        pcmux_sel    = PCMUX_PC_INC;
        addr1mux_sel = ADDR1MUX_PC;
        addr2mux_sel = ADDR2MUX_ZERO;
        busy         = (state != BR_IDLE);
        done         = (state == BR_DONE);
        taken        = (state == BR_DONE) && taken_flag;
        if (state == BR_TAKEN) begin
            ld_pc        = 1'b1;
            pcmux_sel    = PCMUX_ADDER;
            addr1mux_sel = ADDR1MUX_PC;
            addr2mux_sel = ADDR2MUX_OFF9;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_taken),
        .count (taken_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_not_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_not_taken),
        .count (not_taken_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_br_sequencer.sv
// Scoreboard bench for br_sequencer: a BEN register model feeds the DUT and a
// reference model predicts branch outcome, latency and counter values.
`default_nettype none

module tb_br_sequencer;

    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             decode_start;
    logic [15:0]      ir;
    logic             ben;
    logic             ld_ben;
    logic             ld_pc;
    logic [1:0]       pcmux_sel;
    logic             addr1mux_sel;
    logic [1:0]       addr2mux_sel;
    logic             busy;
    logic             done;
    logic             taken;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] not_taken_cnt;

    br_sequencer #(.OPCODE_BR(4'b0000), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .decode_start  (decode_start),
        .ir            (ir),
        .ben           (ben),
        .ld_ben        (ld_ben),
        .ld_pc         (ld_pc),
        .pcmux_sel     (pcmux_sel),
        .addr1mux_sel  (addr1mux_sel),
        .addr2mux_sel  (addr2mux_sel),
        .busy          (busy),
        .done          (done),
        .taken         (taken),
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath condition codes and BEN register model.
    logic fn = 1'b0, fz = 1'b0, fp = 1'b0;
    always @(posedge clk) begin
        if (reset) ben <= 1'b0;
        else if (ld_ben) ben <= (ir[11] & fn) | (ir[10] & fz) | (ir[9] & fp);
    end

    typedef struct {
        int c0;
        bit is_br;
        bit tk;
        int tcnt;
        int ncnt;
    } exp_t;

    exp_t sb[$];
    exp_t popped;
    int vectors = 0;
    int errors  = 0;
    int model_t = 0;
    int model_n = 0;
    int done_cnt = 0;

    function automatic void check(string name, longint act, longint expv);
        vectors++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic int sat_inc(int x);
        return (x + 1 > SAT) ? SAT : x + 1;
    endfunction

    // Monitor: compares DUT events against the front of the scoreboard.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!reset) begin
            if (ld_ben) begin
                if (sb.size() == 0) check("unexpected_ld_ben", 1, 0);
                else check("ld_ben_cycle", cyc - sb[0].c0, 1);
            end
            if (ld_pc) begin
                if (sb.size() == 0) check("unexpected_ld_pc", 1, 0);
                else begin
                    check("ld_pc_only_taken", 1, sb[0].tk);
                    check("ld_pc_cycle", cyc - sb[0].c0, 3);
                    check("pcmux_sel", pcmux_sel, 2'b01);
                    check("addr1mux_sel", addr1mux_sel, 1'b0);
                    check("addr2mux_sel", addr2mux_sel, 2'b10);
                end
            end
            if (done) begin
                if (sb.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    popped = sb.pop_front();
                    check("done_cycle", cyc - popped.c0,
                          !popped.is_br ? 2 : (popped.tk ? 4 : 3));
                    check("taken", taken, popped.tk);
                    check("taken_cnt", taken_cnt, popped.tcnt);
                    check("not_taken_cnt", not_taken_cnt, popped.ncnt);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] i, input bit n, input bit z, input bit p,
                         input bit extra);
        exp_t e;
        bit   br;
        bit   tk;
        br = (i[15:12] == 4'b0000);
        tk = br && (((i[11] & n) | (i[10] & z) | (i[9] & p)) == 1'b1);
        if (br) begin
            if (tk) model_t = sat_inc(model_t);
            else    model_n = sat_inc(model_n);
        end
        @(negedge clk); #1;
        e.c0 = cyc; e.is_br = br; e.tk = tk; e.tcnt = model_t; e.ncnt = model_n;
        sb.push_back(e);
        ir = i; fn = n; fz = z; fp = p;
        decode_start = 1'b1;
        @(negedge clk); #1;
        decode_start = extra;
        if (extra) begin
            repeat (2) begin @(negedge clk); #1; end
            decode_start = 1'b0;
        end
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        model_t = 0;
        model_n = 0;
    endtask

    initial begin
        int d0;
        logic [15:0] ri;
        reset = 1'b1; decode_start = 1'b0; ir = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_ld_ben", ld_ben, 0);
        check("rst_ld_pc", ld_pc, 0);
        check("rst_pcmux", pcmux_sel, 0);
        check("rst_addr1mux", addr1mux_sel, 0);
        check("rst_addr2mux", addr2mux_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_taken", taken, 0);
        check("rst_taken_cnt", taken_cnt, 0);
        check("rst_not_taken_cnt", not_taken_cnt, 0);
        #1 reset = 1'b0;

        issue(16'h0405, 1'b0, 1'b1, 1'b0, 1'b0);   // BRz, Z set: taken
        issue(16'h0405, 1'b0, 1'b0, 1'b1, 1'b0);   // BRz, P set: not taken
        issue(16'h1261, 1'b0, 1'b1, 1'b0, 1'b0);   // ADD: no branch activity

        d0 = done_cnt;
        issue(16'h0405, 1'b0, 1'b1, 1'b0, 1'b1);   // extra starts while busy
        repeat (4) @(negedge clk);
        check("busy_single_done", done_cnt - d0, 1);
        issue(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);   // NOP branch: not taken

        for (int t = 0; t < 40; t++) begin
            ri = 16'($urandom);
            if ($urandom_range(0, 1) == 0) ri[15:12] = 4'b0000;
            case ($urandom_range(0, 2))
                0:       issue(ri, 1'b1, 1'b0, 1'b0, 1'b0);
                1:       issue(ri, 1'b0, 1'b1, 1'b0, 1'b0);
                default: issue(ri, 1'b0, 1'b0, 1'b1, 1'b0);
            endcase
        end

        // Reset mid-operation with prior counts 5/7.
        do_reset();
        for (int t = 0; t < 5; t++) issue(16'h0E10, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 7; t++) issue(16'h0810, 1'b0, 1'b1, 1'b1, 1'b0);
        check("pre_reset_taken_cnt", taken_cnt, 5);
        check("pre_reset_not_taken_cnt", not_taken_cnt, 7);
        @(negedge clk); #1;
        begin
            exp_t e;
            model_t = sat_inc(model_t);
            e.c0 = cyc; e.is_br = 1'b1; e.tk = 1'b1; e.tcnt = model_t; e.ncnt = model_n;
            sb.push_back(e);
        end
        ir = 16'h0405; fn = 1'b0; fz = 1'b1; fp = 1'b0;
        decode_start = 1'b1;
        @(negedge clk); #1 decode_start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_pre_ld_pc", ld_pc, 1);
        #1 reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_ld_pc", ld_pc, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_taken_cnt", taken_cnt, 0);
        check("mid_not_taken_cnt", not_taken_cnt, 0);
        #1 reset = 1'b0;
        model_t = 0; model_n = 0;
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        check("mid_no_done_after", done_cnt - d0, 0);

        // Saturation of the 4-bit taken counter.
        for (int t = 0; t < 17; t++) issue(16'h0405, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sat_taken_cnt", taken_cnt, 4'hF);
        check("sat_not_taken_cnt", not_taken_cnt, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
